if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program-counter register and the next-PC mux (PC+4, branch, jump), and drives the instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register, with hazard-unit stall, flush and memory wait handling.
- Feeds the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID as a bubble (sll $0,$0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall_if  input  1  hazard unit: hold PC and IF/ID (load-use stall)
flush_if  input  1  squash IF/ID contents to a bubble
branch_taken  input  1  EX-stage branch resolved taken
branch_target  input  32  branch destination byte address
jump  input  1  jump (j/jal/jr) redirect request
jump_target  input  32  jump destination byte address
imem_addr  output  32  instruction-memory byte address, equal to the current PC
imem_rdata  input  32  instruction word at imem_addr
imem_ready  input  1  imem_rdata valid this cycle
pc_out  output  32  current PC (debug/trace)
ifid_pc4  output  32  registered PC+4 of the instruction held in IF/ID
ifid_instr  output  32  registered instruction
ifid_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0. First fetch starts in the first cycle after rst deasserts.
- Combinational outputs: imem_addr = pc_out = pc register. No combinational path from imem_rdata to any output.
- pc_plus4 = pc + 4, modulo 2^32. FFFF_FFFC wraps to 0000_0000.
- Redirect targets have bits [1:0] forced to 00 before loading into the PC.
- Per-cycle priority, first match wins:
  1. branch_taken: pc <= branch_target; IF/ID <= bubble.
  2. jump: pc <= jump_target; IF/ID <= bubble. If branch_taken and jump are both asserted, the branch wins.
  3. stall_if: pc holds. IF/ID holds, unless flush_if, in which case IF/ID <= bubble.
  4. imem_ready=0: pc holds; IF/ID <= bubble (valid=0). This holds regardless of the wait length.
  5. Otherwise: pc <= pc_plus4; ifid_instr <= imem_rdata; ifid_pc4 <= pc_plus4; ifid_valid <= 1. If flush_if is also asserted, the PC still advances but IF/ID <= bubble.
- Bubble definition: ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0.
- A redirect overrides a stall and an outstanding memory wait. The pending fetch is abandoned and the new address is presented the next cycle.
- Latency: an instruction at address A appears on ifid_instr one cycle after the cycle in which pc=A and imem_ready=1.
- Reset asserted mid-wait or mid-stall: all state returns to reset values. No residual valid instruction.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC and NOP_INSTR defaults
  - WORD_BYTES=4
  - the IF/ID bundle typedef ifid_t {pc4[31:0], instr[31:0], valid}, also consumed by the decode stage
- One natural sub-module, ifid_reg: the IF/ID register with load, hold and bubble controls and async reset.
- Next-PC mux and PC register stay inline in if_stage.

Test Plan:
- Reset, then imem_ready=1 for 4 cycles, with imem returning instr=addr^32'hA5A5_0000 → pc_out 0,4,8,C,10; ifid_instr lags one cycle; ifid_pc4=4,8,C,10; ifid_valid=1 from the 2nd cycle.
- At pc=8, branch_taken=1 and branch_target=32'h0000_0103 for 1 cycle → next pc=0000_0100; IF/ID is a bubble that cycle; fetch resumes at 104.
- At pc=0000_0010, stall_if=1 for 2 cycles → pc holds at 10 and IF/ID holds its prior instruction for both cycles; 3rd cycle pc=14.
- At pc=20, imem_ready=0 for 3 cycles → pc holds at 20 and ifid_valid=0 for 3 cycles. Then ready=1: ifid_instr=word@20, pc=24.
- branch_taken=1 (target 200) and jump=1 (target 300) in the same cycle, with stall_if=1 → pc=200 next cycle, IF/ID bubble.
- Set pc to FFFF_FFFC via jump, with ready=1 → next pc=0000_0000 and ifid_pc4=0. Then assert rst asynchronously mid-cycle → outputs return to reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by fetch and decode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   RESET_PC_DEFAULT  - default PC after reset
//   NOP_INSTR_DEFAULT - bubble encoding (sll $0,$0,0)
//   WORD_BYTES        - instruction size in bytes
//   ifid_t            - IF/ID pipeline bundle, also consumed by decode
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam int unsigned WORD_BYTES        = 4;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   // Instructions are word aligned, so redirect targets drop their byte offset.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Empty IF/ID slot: decode sees a NOP that it must not retire.
   function automatic ifid_t make_bubble(input logic [31:0] nop);
      ifid_t b;
      b.pc4   = 32'd0;
      b.instr = nop;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Latency: 1 cycle from load/bubble to q.
// Backpressure: load=0 and bubble=0 holds the current contents.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset (reset value is a bubble)
//   load     - capture d
//   bubble   - replace contents with a bubble; takes precedence over load
//   d        - next IF/ID contents
//   q        - registered IF/ID contents
module ifid_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  bubble,
   input  ifid_t d,
   output ifid_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= make_bubble(NOP_INSTR);
      end else if (bubble) begin
         q <= make_bubble(NOP_INSTR);
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC register, next-PC mux, IF/ID capture.
// Latency: instruction at PC=A appears on ifid_instr one cycle after pc=A with imem_ready=1.
// Backpressure: stall_if or imem_ready=0 hold the PC; redirects override both.
//
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   stall_if, flush_if           - hazard-unit hold / squash of IF/ID
//   branch_taken, branch_target  - EX-resolved branch redirect (highest priority)
//   jump, jump_target            - jump redirect
//   imem_addr, imem_rdata, imem_ready - instruction memory interface
//   pc_out                       - current PC for trace
//   ifid_pc4, ifid_instr, ifid_valid - IF/ID register outputs to decode
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        flush_if,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic        ifid_load;
   logic        ifid_bubble;
   ifid_t       ifid_d;
   ifid_t       ifid_q;

   // Wraps naturally at 2^32.
   assign pc_plus4 = pc_q + 32'(WORD_BYTES);

   // Next-PC and IF/ID control, first match wins. A redirect abandons any
   // pending fetch (stalled or waiting on memory) and squashes IF/ID, since
   // whatever was fetched down the old path is wrong.
   always_comb begin
      pc_d        = pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      if (branch_taken) begin
         pc_d        = align_word(branch_target);
         ifid_bubble = 1'b1;
      end else if (jump) begin
         pc_d        = align_word(jump_target);
         ifid_bubble = 1'b1;
      end else if (stall_if) begin
         // Load-use stall: IF/ID keeps its instruction unless decode is flushing.
         ifid_bubble = flush_if;
      end else if (!imem_ready) begin
         // Memory wait: nothing valid to hand to decode this cycle.
         ifid_bubble = 1'b1;
      end else begin
         pc_d        = pc_plus4;
         ifid_load   = !flush_if;
         ifid_bubble = flush_if;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign ifid_d.pc4   = pc_plus4;
   assign ifid_d.instr = imem_rdata;
   assign ifid_d.valid = 1'b1;

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (ifid_load),
      .bubble (ifid_bubble),
      .d      (ifid_d),
      .q      (ifid_q)
   );

   assign imem_addr  = pc_q;
   assign pc_out     = pc_q;
   assign ifid_pc4   = ifid_q.pc4;
   assign ifid_instr = ifid_q.instr;
   assign ifid_valid = ifid_q.valid;

endmodule
